text_ram_arbiter: RTL and testbench
===================================

Name: text_ram_arbiter

Overview:
- Shares one single-port character RAM (TEXT_CHARS entries, 1-cycle registered read) between three users:
  - the video fetch path, driven by the character counter's character_pos; highest priority, fixed latency;
  - a background screen-clear engine;
  - the CPU bus port, req/ack handshake.
- Sits between the character counter / font lookup and the text RAM.
- Guarantees the 2-clock fetch latency that the counter's ADVANCE provides.

Parameters:
- TEXT_CHARS, 1920, number of character cells (80x24).
- ADDR_W, 11, address width.
- DATA_W, 8, character code width.
- FILL_CHAR, 8'h20, value written by screen clear.

Ports:
- CLK  in  1  system/pixel clock.
- RST  in  1  synchronous, active-high reset.
- vid_req  in  1  one-cycle pulse: fetch vid_addr now.
- vid_addr  in  ADDR_W  character_pos from the character counter.
- vid_data  out  DATA_W  fetched character code; held until the next video fetch.
- vid_valid  out  1  pulse: vid_data updated this cycle.
- cpu_req  in  1  level; fields held stable until cpu_ack.
- cpu_we  in  1  1=write, 0=read.
- cpu_addr  in  ADDR_W  CPU cell address.
- cpu_wdata  in  DATA_W  write data.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_rdata  out  DATA_W  read data; valid in the cpu_ack cycle, held afterwards.
- clr_start  in  1  pulse: fill the whole RAM with FILL_CHAR.
- clr_busy  out  1  clear in progress.
- ram_addr  out  ADDR_W  RAM address (combinational mux).
- ram_we  out  1  RAM write enable (combinational).
- ram_wdata  out  DATA_W  RAM write data.
- ram_rdata  in  DATA_W  RAM read data, valid the cycle after the address.

Behaviour:
- Reset state (RST high at an edge):
  - vid_data=0, vid_valid=0, cpu_ack=0, cpu_rdata=0, clr_busy=0;
  - CPU FSM goes to IDLE and the clear counter to 0;
  - in-flight operations are abandoned, and ram_we is forced 0 in any cycle where RST=1.
- Port priority each cycle: video > clear > CPU.
- Video path:
  - In cycle N with vid_req=1: ram_addr=vid_addr, ram_we=0.
  - ram_rdata is registered into vid_data at the end of N+1. vid_data and vid_valid are visible in N+2, which is a fixed 2-cycle latency.
  - Never stalled.
  - If vid_addr >= TEXT_CHARS, vid_data=0 and the RAM read is still issued.
- Clear engine:
  - clr_start while clr_busy=0 sets clr_busy=1 next cycle with counter=0. clr_start while busy is ignored.
  - Each cycle with clr_busy=1 and vid_req=0, it writes FILL_CHAR to address counter, then increments.
  - After writing TEXT_CHARS-1, clr_busy drops at the next edge.
  - Total duration = TEXT_CHARS non-video cycles.
- CPU FSM, states IDLE, RD_WAIT, ACK:
  - Grant occurs in IDLE when cpu_req=1 and vid_req=0 and clr_busy=0. ram_addr=cpu_addr in that cycle (G).
  - Write: ram_we=1 in G; go to ACK, so cpu_ack is seen in G+1.
  - Read: go to RD_WAIT. In G+1, ram_rdata is captured into cpu_rdata. Go to ACK, so cpu_ack is seen in G+2.
  - ACK lasts one cycle, then returns to IDLE. No grant is made in the ACK cycle, so back-to-back requests are re-granted no earlier than the cycle after ACK.
  - A video fetch in RD_WAIT is legal because the RAM is pipelined. Both captures go to separate registers.
  - cpu_addr >= TEXT_CHARS: a write is dropped (ram_we=0) but still acked at G+1. A read returns 0 and is acked at G+2.
- clr_start arriving in a grant cycle G: that CPU access completes. Later grants wait until clr_busy=0. A pending cpu_req simply stalls, with no ack, during a clear.
- Width rules:
  - Counter is ADDR_W wide; compare with TEXT_CHARS-1, with no wrap past it.
  - All addresses are unsigned.

Decomposition:
- Shared package text_pkg holds:
  - TEXT_CHARS, ADDR_W, DATA_W, FILL_CHAR;
  - the CPU FSM state encoding (IDLE=0, RD_WAIT=1, ACK=2).
- One natural sub-module, text_clear_engine: the counter, clr_busy, and per-cycle write request/address. It takes the vid_req stall input.
- The arbiter mux and CPU FSM stay in the top-level module.

Test Plan:
- Video latency: vid_req at cycle 10 with vid_addr=5 and RAM[5]=8'h41 -> ram_addr=5 in cycle 10; vid_data=8'h41 and vid_valid=1 in cycle 12 only.
- CPU write then read: write 8'h7A to 100 with no video traffic -> ram_we=1 in G, cpu_ack at G+1. Read of 100 -> cpu_ack at G+2 with cpu_rdata=8'h7A.
- Contention: cpu_req (read 3) and vid_req both asserted in cycle N -> video owns ram_addr in N, the CPU is granted in N+1, and cpu_ack arrives at N+3. vid_valid arrives at N+2 and is unaffected.
- Clear:
  - clr_start with vid_req pulsing every 10th cycle -> all 1920 cells read 8'h20;
  - clr_busy is high for exactly 1920 + (number of vid_req cycles in the window) cycles;
  - a cpu_req held meanwhile is acked only after clr_busy=0.
- Out of range: CPU write to 1920 -> no ram_we, ack at G+1. Read of 2047 -> cpu_rdata=0. vid_addr=1920 -> vid_data=0.
- Reset mid-operation: RST asserted in RD_WAIT and mid-clear (counter=500) -> next cycle cpu_ack=0, clr_busy=0, ram_we=0. A fresh request after reset completes normally.

Source files
------------

// File: rtl/text_ram_arbiter_pkg.sv
// Shared constants, FSM encoding and RAM command type for the text RAM arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package text_pkg;

  localparam int TEXT_CHARS = 1920;
  localparam int ADDR_W     = 11;
  localparam int DATA_W     = 8;

  localparam logic [DATA_W-1:0] FILL_CHAR = 8'h20;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(TEXT_CHARS - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    ACK     = 2'd2
  } cpu_state_t;

  // One RAM access as presented on the single port.
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } ram_cmd_t;

  // True when the cell address exists in the character RAM.
  function automatic logic addr_ok(input logic [ADDR_W-1:0] addr);
    return addr < ADDR_W'(TEXT_CHARS);
  endfunction

endpackage

// File: rtl/text_ram_arbiter_clear_engine.sv
// Screen-clear engine: sweeps every cell writing FILL_CHAR, one cell per free cycle.
// Latency: busy from the cycle after clr_start; TEXT_CHARS non-video cycles in total.
// Backpressure: holds its counter in any cycle where vid_req is high.
module text_clear_engine
  import text_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_start,
  input  logic              vid_req,
  output logic              clr_busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  logic [ADDR_W-1:0] cnt;

  // Start, advance and finish the sweep; a start while busy is ignored and
  // the counter parks on the last cell instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      clr_busy <= 1'b0;
      cnt      <= '0;
    end else if (!clr_busy) begin
      if (clr_start) begin
        clr_busy <= 1'b1;
        cnt      <= '0;
      end
    end else if (!vid_req) begin
      if (cnt == LAST_ADDR) begin
        clr_busy <= 1'b0;
      end else begin
        cnt <= cnt + ADDR_W'(1);
      end
    end
  end

  // A write is issued only in cycles the video path leaves free.
  assign clr_we   = clr_busy && !vid_req;
  assign clr_addr = cnt;

endmodule

// File: rtl/text_ram_arbiter.sv
// Three-way arbiter for the single-port text RAM: video fetch > screen clear > CPU.
// Latency: video data 2 cycles after vid_req; CPU write ack G+1, read ack G+2.
// Backpressure: video never stalls; clear stalls on video; CPU waits (no ack) while busy.
module text_ram_arbiter
  import text_pkg::*;
(
  input  logic              CLK,
  input  logic              RST,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic [DATA_W-1:0] vid_data,
  output logic              vid_valid,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              clr_start,
  output logic              clr_busy,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  cpu_state_t        state;
  logic              cpu_grant;
  logic              rd_oor;
  logic              vid_p1;
  logic              vid_oor_p1;
  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  ram_cmd_t          cmd;

  text_clear_engine u_clear (
    .clk       (CLK),
    .rst       (RST),
    .clr_start (clr_start),
    .vid_req   (vid_req),
    .clr_busy  (clr_busy),
    .clr_we    (clr_we),
    .clr_addr  (clr_addr)
  );

  // The CPU only gets the port when idle and nobody with higher priority wants it.
  assign cpu_grant = (state == IDLE) && cpu_req && !vid_req && !clr_busy;

  // Port mux: video > clear > CPU; writes are suppressed during reset and for
  // CPU addresses outside the character array.
  always_comb begin
    cmd = '{we: 1'b0, addr: cpu_addr, wdata: cpu_wdata};
    if (vid_req) begin
      cmd.addr = vid_addr;
    end else if (clr_we) begin
      cmd.we    = 1'b1;
      cmd.addr  = clr_addr;
      cmd.wdata = FILL_CHAR;
    end else if (cpu_grant) begin
      cmd.we = cpu_we && addr_ok(cpu_addr);
    end
    if (RST) begin
      cmd.we = 1'b0;
    end
  end

  assign ram_addr  = cmd.addr;
  assign ram_we    = cmd.we;
  assign ram_wdata = cmd.wdata;

  // Video fetch pipeline: tag the request, capture the RAM output one cycle later.
  always_ff @(posedge CLK) begin
    if (RST) begin
      vid_p1     <= 1'b0;
      vid_oor_p1 <= 1'b0;
      vid_valid  <= 1'b0;
      vid_data   <= '0;
    end else begin
      vid_p1     <= vid_req;
      vid_oor_p1 <= !addr_ok(vid_addr);
      vid_valid  <= vid_p1;
      if (vid_p1) begin
        vid_data <= vid_oor_p1 ? '0 : ram_rdata;
      end
    end
  end

  // CPU access FSM: grant, optional read wait, then a single ack cycle during
  // which no new grant is made.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      cpu_ack   <= 1'b0;
      cpu_rdata <= '0;
      rd_oor    <= 1'b0;
    end else begin
      cpu_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (cpu_grant) begin
            rd_oor <= !addr_ok(cpu_addr);
            if (cpu_we) begin
              state   <= ACK;
              cpu_ack <= 1'b1;
            end else begin
              state <= RD_WAIT;
            end
          end
        end
        RD_WAIT: begin
          cpu_rdata <= rd_oor ? '0 : ram_rdata;
          cpu_ack   <= 1'b1;
          state     <= ACK;
        end
        ACK: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_text_ram_arbiter.sv
// Self-checking bench for text_ram_arbiter with a behavioural single-port RAM.
// Latency: expectations carry the cycle they are due in and are checked on arrival.
// Backpressure: every wait is a bounded cycle loop.
module tb_text_ram_arbiter;

  localparam int N_CHARS = 1920;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        vid_req = 1'b0;
  logic [10:0] vid_addr = '0;
  logic [7:0]  vid_data;
  logic        vid_valid;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [10:0] cpu_addr = '0;
  logic [7:0]  cpu_wdata = '0;
  logic        cpu_ack;
  logic [7:0]  cpu_rdata;
  logic        clr_start = 1'b0;
  logic        clr_busy;
  logic [10:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata;

  text_ram_arbiter dut (
    .CLK       (CLK),
    .RST       (RST),
    .vid_req   (vid_req),
    .vid_addr  (vid_addr),
    .vid_data  (vid_data),
    .vid_valid (vid_valid),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_ack   (cpu_ack),
    .cpu_rdata (cpu_rdata),
    .clr_start (clr_start),
    .clr_busy  (clr_busy),
    .ram_addr  (ram_addr),
    .ram_we    (ram_we),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Single-port RAM, registered read; a preload port is used while in reset.
  logic [7:0]  ram_mem [0:2047];
  logic        load = 1'b0;
  logic [10:0] load_addr = '0;
  logic [7:0]  load_data = '0;
  always @(posedge CLK) begin
    if (load) ram_mem[load_addr] <= load_data;
    else if (ram_we) ram_mem[ram_addr] <= ram_wdata;
    ram_rdata <= ram_mem[ram_addr];
  end

  typedef struct { int due; logic [7:0] data; } vexp_t;
  typedef struct { int due; logic rd; logic [7:0] data; } cexp_t;
  vexp_t vq[$];
  cexp_t cq[$];

  typedef enum logic [1:0] { OP_VID, OP_WR, OP_RD } op_t;
  typedef struct { op_t op; logic [10:0] addr; logic [7:0] wdata; logic [7:0] exp; } vec_t;
  vec_t vecs [13];

  logic [7:0] exp_mem [0:2047];
  logic [7:0] vid_hold = 8'h00;
  logic [7:0] cpu_hold = 8'h00;
  int checks = 0;
  int failures = 0;

  function automatic logic [7:0] init_val(input int a);
    if (a == 5) return 8'h41;
    if (a >= N_CHARS) return 8'hEE;
    return 8'(a) + 8'h11;
  endfunction

  task automatic report_fail(input string name, input logic [31:0] act, input logic [31:0] exp);
    failures++;
    $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) report_fail(name, act, exp);
  endtask

  // Per-cycle observer: RAM write sanity plus both scoreboards.
  task automatic sample();
    if (RST) chk("ram_we_in_reset", 32'(ram_we), 0);
    if (ram_we) chk("ram_we_addr_range", 32'(ram_addr < 11'd1920), 1);
    if (vq.size() > 0 && vq[0].due < cyc) begin
      checks++; report_fail("vid_valid_missing", 0, 1); vq.delete(0);
    end
    if (vid_valid) begin
      if (vq.size() == 0 || vq[0].due != cyc) begin
        checks++; report_fail("vid_valid_unexpected", 1, 0);
      end else begin
        chk("vid_data", 32'(vid_data), 32'(vq[0].data));
        vid_hold = vq[0].data;
        vq.delete(0);
      end
    end else chk("vid_data_hold", 32'(vid_data), 32'(vid_hold));
    if (cq.size() > 0 && cq[0].due < cyc) begin
      checks++; report_fail("cpu_ack_missing", 0, 1); cq.delete(0);
    end
    if (cpu_ack) begin
      if (cq.size() == 0 || cq[0].due != cyc) begin
        checks++; report_fail("cpu_ack_unexpected", 1, 0);
      end else begin
        if (cq[0].rd) begin
          chk("cpu_rdata", 32'(cpu_rdata), 32'(cq[0].data));
          cpu_hold = cq[0].data;
        end
        cq.delete(0);
      end
    end else chk("cpu_rdata_hold", 32'(cpu_rdata), 32'(cpu_hold));
    if (RST) begin
      vid_hold = 8'h00; cpu_hold = 8'h00; vq.delete(); cq.delete();
    end
  endtask

  task automatic tick();
    #1; sample(); @(negedge CLK);
  endtask

  task automatic do_vid(input logic [10:0] a, input logic [7:0] e);
    vid_req = 1'b1; vid_addr = a;
    vq.push_back('{due: cyc + 2, data: e});
    #1;
    chk("vid_ram_addr", 32'(ram_addr), 32'(a));
    chk("vid_ram_we", 32'(ram_we), 0);
    tick();
    vid_req = 1'b0;
    tick(); tick();
  endtask

  // CPU access on an otherwise idle port: grant in the drive cycle.
  task automatic do_cpu(input logic we, input logic [10:0] a, input logic [7:0] d, input logic [7:0] e);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    cq.push_back('{due: cyc + (we ? 1 : 2), rd: !we, data: e});
    #1;
    chk("cpu_ram_addr", 32'(ram_addr), 32'(a));
    chk("cpu_ram_we", 32'(ram_we), 32'(we && (a < 11'd1920)));
    if (we && a < 11'd1920) begin
      chk("cpu_ram_wdata", 32'(ram_wdata), 32'(d));
      exp_mem[a] = d;
    end
    tick();
    if (!we) tick();
    tick();
    cpu_req = 1'b0; cpu_we = 1'b0;
  endtask

  initial begin
    int busy_cycles;
    int vids;
    int cleared;

    for (int i = 0; i < 2048; i++) exp_mem[i] = init_val(i);
    vecs[0]  = '{OP_VID, 11'd5,    8'h00, 8'h41};
    vecs[1]  = '{OP_WR,  11'd100,  8'h7A, 8'h00};
    vecs[2]  = '{OP_RD,  11'd100,  8'h00, 8'h7A};
    vecs[3]  = '{OP_VID, 11'd100,  8'h00, 8'h7A};
    vecs[4]  = '{OP_WR,  11'd1920, 8'h55, 8'h00};
    vecs[5]  = '{OP_RD,  11'd1920, 8'h00, 8'h00};
    vecs[6]  = '{OP_RD,  11'd2047, 8'h00, 8'h00};
    vecs[7]  = '{OP_VID, 11'd1920, 8'h00, 8'h00};
    vecs[8]  = '{OP_VID, 11'd1919, 8'h00, 8'h90};
    vecs[9]  = '{OP_RD,  11'd1919, 8'h00, 8'h90};
    vecs[10] = '{OP_WR,  11'd0,    8'hA5, 8'h00};
    vecs[11] = '{OP_VID, 11'd0,    8'h00, 8'hA5};
    vecs[12] = '{OP_VID, 11'd2047, 8'h00, 8'h00};

    @(negedge CLK);
    // Preload the RAM while reset is held.
    load = 1'b1;
    for (int i = 0; i < 2048; i++) begin
      load_addr = 11'(i); load_data = exp_mem[i]; tick();
    end
    load = 1'b0;

    // Reset state, with a CPU write request present during reset.
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 11'd10; cpu_wdata = 8'hFF;
    #1;
    chk("rst_ram_we", 32'(ram_we), 0);
    chk("rst_vid_data", 32'(vid_data), 0);
    chk("rst_vid_valid", 32'(vid_valid), 0);
    chk("rst_cpu_ack", 32'(cpu_ack), 0);
    chk("rst_cpu_rdata", 32'(cpu_rdata), 0);
    chk("rst_clr_busy", 32'(clr_busy), 0);
    tick();
    cpu_req = 1'b0; cpu_we = 1'b0; RST = 1'b0;
    tick(); tick();

    // Table-driven single transactions.
    for (int i = 0; i < 13; i++) begin
      case (vecs[i].op)
        OP_VID:  do_vid(vecs[i].addr, vecs[i].exp);
        OP_WR:   do_cpu(1'b1, vecs[i].addr, vecs[i].wdata, 8'h00);
        default: do_cpu(1'b0, vecs[i].addr, 8'h00, vecs[i].exp);
      endcase
    end

    // Contention: video and CPU read in the same cycle N.
    vid_req = 1'b1; vid_addr = 11'd7; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 11'd3;
    vq.push_back('{due: cyc + 2, data: exp_mem[7]});
    cq.push_back('{due: cyc + 3, rd: 1'b1, data: exp_mem[3]});
    #1; chk("cont_vid_addr", 32'(ram_addr), 7);
    tick();
    vid_req = 1'b0;
    #1; chk("cont_cpu_addr", 32'(ram_addr), 3);
    tick(); tick(); tick();
    cpu_req = 1'b0;

    // Video fetch landing in the CPU read-wait cycle.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 11'd100;
    cq.push_back('{due: cyc + 2, rd: 1'b1, data: exp_mem[100]});
    tick();
    vid_req = 1'b1; vid_addr = 11'd9;
    vq.push_back('{due: cyc + 2, data: exp_mem[9]});
    #1; chk("rdwait_vid_addr", 32'(ram_addr), 9);
    tick();
    vid_req = 1'b0;
    tick();
    cpu_req = 1'b0;
    tick(); tick();

    // Reset while a CPU read sits in RD_WAIT.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 11'd3;
    #1; chk("rst_rd_grant_addr", 32'(ram_addr), 3);
    tick();
    cpu_req = 1'b0; RST = 1'b1;
    tick();
    RST = 1'b0;
    #1;
    chk("rst_rd_cpu_ack", 32'(cpu_ack), 0);
    chk("rst_rd_clr_busy", 32'(clr_busy), 0);
    chk("rst_rd_ram_we", 32'(ram_we), 0);
    tick();
    do_cpu(1'b0, 11'd3, 8'h00, exp_mem[3]);

    // Reset part-way through a clear, with the counter at 500.
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    chk("midclr_busy", 32'(clr_busy), 1);
    for (int k = 0; k < 500; k++) begin
      if (k == 0 || k == 499) begin
        #1;
        chk("midclr_addr", 32'(ram_addr), 32'(k));
        chk("midclr_we", 32'(ram_we), 1);
        chk("midclr_wdata", 32'(ram_wdata), 'h20);
      end
      tick();
    end
    RST = 1'b1;
    #1; chk("midclr_rst_we", 32'(ram_we), 0);
    tick();
    RST = 1'b0;
    #1;
    chk("midclr_after_busy", 32'(clr_busy), 0);
    chk("midclr_after_ack", 32'(cpu_ack), 0);
    chk("midclr_after_we", 32'(ram_we), 0);
    tick();
    for (int i = 0; i < 500; i++) exp_mem[i] = 8'h20;
    do_vid(11'd499, exp_mem[499]);
    do_vid(11'd500, exp_mem[500]);
    do_vid(11'd600, exp_mem[600]);
    do_cpu(1'b1, 11'd300, 8'h66, 8'h00);
    do_cpu(1'b0, 11'd300, 8'h00, 8'h66);

    // Full clear: CPU write granted in the start cycle, then a read held across it.
    clr_start = 1'b1; cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 11'd200; cpu_wdata = 8'h33;
    cq.push_back('{due: cyc + 1, rd: 1'b0, data: 8'h00});
    #1;
    chk("clr_g_we", 32'(ram_we), 1);
    chk("clr_g_addr", 32'(ram_addr), 200);
    exp_mem[200] = 8'h33;
    tick();
    clr_start = 1'b0; cpu_we = 1'b0;
    busy_cycles = 0; vids = 0; cleared = 0;
    for (int k = 0; k < 4000; k++) begin
      if (!clr_busy) break;
      vid_req = (k % 10 == 0);
      vid_addr = 11'((k * 37) % N_CHARS);
      clr_start = (k == 50);
      busy_cycles++;
      if (vid_req) begin
        vids++;
        vq.push_back('{due: cyc + 2, data: (int'(vid_addr) < cleared) ? 8'h20 : exp_mem[vid_addr]});
      end else cleared++;
      tick();
    end
    clr_start = 1'b0; vid_req = 1'b0;
    chk("clr_busy_cycles", 32'(busy_cycles), 32'(N_CHARS + vids));
    chk("clr_write_cycles", 32'(cleared), 32'(N_CHARS));
    cq.push_back('{due: cyc + 2, rd: 1'b1, data: 8'h20});
    #1; chk("clr_held_grant_addr", 32'(ram_addr), 200);
    tick(); tick(); tick();
    cpu_req = 1'b0;
    for (int i = 0; i < N_CHARS; i++) exp_mem[i] = 8'h20;

    // Read back every cell through the video path, one fetch per cycle.
    for (int a = 0; a < N_CHARS; a++) begin
      vid_req = 1'b1; vid_addr = 11'(a);
      vq.push_back('{due: cyc + 2, data: exp_mem[a]});
      tick();
    end
    vid_req = 1'b0;
    repeat (4) tick();

    chk("vid_scoreboard_empty", 32'(vq.size()), 0);
    chk("cpu_scoreboard_empty", 32'(cq.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
